// File: rtl/window_max_finder_if.sv
// Sample/result handshake bundle for window_max_finder.
// out_idx exists only when ARGMAX_IDX_EN is defined.
interface window_max_finder_if #(
  parameter int DW = 8,
  parameter int N  = 8
);
  localparam int IW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_max;
`ifdef ARGMAX_IDX_EN
  logic [IW-1:0] out_idx;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_idx
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_idx
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max
  );
`endif
endinterface

// File: rtl/window_max_finder.sv
// Streaming window maximum over N unsigned samples with one reused comparator.
// Define ARGMAX_IDX_EN to also track and report the position of the maximum.
//
// state | meaning
// ACCUM | accepting samples, folding each into the running maximum
// HOLD  | window result presented, waiting for the consumer
module window_max_finder #(
  parameter int DW = 8,
  parameter int N  = 8
) (
  input logic                clk,
  input logic                rst_n,
  input logic                clr,
  window_max_finder_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt;
  logic [DW-1:0] max_r;
  logic [DW-1:0] max_nx;
  logic [DW-1:0] out_max_r;
  logic          in_ready_c;
  logic          out_valid_c;
  logic          accept;
  logic          take_new;
  logic          last;

  assign accept   = bus.in_valid & in_ready_c;
  assign last     = (cnt == LAST);
  // First sample of a window always seeds; later ones must be strictly larger.
  assign take_new = (cnt == '0) || (bus.in_data > max_r);
  assign max_nx   = take_new ? bus.in_data : max_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready_c = 1'b1;
        if (accept && last) state_d = HOLD;
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    if (clr) state_d = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      max_r     <= '0;
      out_max_r <= '0;
    end else if (clr) begin
      cnt       <= '0;
      max_r     <= '0;
      out_max_r <= '0;
    end else if (accept) begin
      cnt   <= last ? '0 : cnt + IW'(1);
      max_r <= max_nx;
      if (last) out_max_r <= max_nx;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_max   = out_max_r;

`ifdef ARGMAX_IDX_EN
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_nx;
  logic [IW-1:0] out_idx_r;

  assign idx_nx = take_new ? cnt : idx_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= '0;
      out_idx_r <= '0;
    end else if (clr) begin
      idx_r     <= '0;
      out_idx_r <= '0;
    end else if (accept) begin
      idx_r <= idx_nx;
      if (last) out_idx_r <= idx_nx;
    end
  end

  assign bus.out_idx = out_idx_r;
`endif
endmodule

// File: tb/tb_window_max_finder.sv
// Directed bench for window_max_finder (DW=8, N=8), hand-computed expectations.
module tb_window_max_finder;
  logic clk;
  logic rst_n;
  logic clr;
  int   n_checks;
  int   n_fail;
  int   acc_cnt;

  window_max_finder_if #(.DW(8), .N(8)) bus ();

  window_max_finder #(.DW(8), .N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.in_valid && bus.in_ready) acc_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and wait (bounded) until it is accepted; in_valid stays high.
  task automatic send(input logic [7:0] d);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_idx(input string tag, input int exp);
`ifdef ARGMAX_IDX_EN
    check(tag, 32'(bus.out_idx), 32'(exp));
`endif
  endtask

  logic [7:0] win2 [8] = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd7, 8'd200, 8'd5, 8'd4};
  int ready_low;

  initial begin
    n_checks = 0; n_fail = 0; acc_cnt = 0;
    rst_n = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_max", 32'(bus.out_max), 32'd0);
    chk_idx("rst_out_idx", 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // back-to-back window, consumer always ready
    for (int i = 0; i < 8; i++) begin
      send(win2[i]);
      if (i == 6) check("t2_no_early_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("t2_out_valid", 32'(bus.out_valid), 32'd1);
    check("t2_out_max", 32'(bus.out_max), 32'd200);
    chk_idx("t2_out_idx", 3);
    ready_low = 0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.in_ready) ready_low++;
      tick();
    end
    check("t2_ready_low_cycles", 32'(ready_low), 32'd1);
    check("t2_out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("t2_max_persist", 32'(bus.out_max), 32'd200);

    // backpressure
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i * 10));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd250;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t3_hold_max", 32'(bus.out_max), 32'd80);
      chk_idx("t3_hold_idx", 7);
      check("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t3_after_xfer_valid", 32'(bus.out_valid), 32'd0);
    check("t3_after_xfer_ready", 32'(bus.in_ready), 32'd1);

    // async reset mid-window
    send(8'd90); send(8'd91); send(8'd92);
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("t1_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t1_rst_out_max", 32'(bus.out_max), 32'd0);
    check("t1_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk_idx("t1_rst_out_idx", 0);
    tick();
    rst_n = 1'b1;
    tick();

    // gaps in in_valid; partial window lost, so 8 fresh accepts complete it
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      send(8'h55);
      if (i == 6) check("t4_no_early_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("t4_accepts", 32'(acc_cnt), 32'd8);
    check("t4_out_valid", 32'(bus.out_valid), 32'd1);
    check("t4_out_max", 32'(bus.out_max), 32'h55);
    chk_idx("t4_out_idx", 0);
    tick();

    // clr mid-window
    send(8'hFF); send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    bus.in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr_out_max", 32'(bus.out_max), 32'd0);
    for (int i = 1; i <= 8; i++) send(8'(i));
    bus.in_valid = 1'b0;
    check("t5_out_valid", 32'(bus.out_valid), 32'd1);
    check("t5_out_max", 32'(bus.out_max), 32'd8);
    chk_idx("t5_out_idx", 7);
    tick();

    // clr while in HOLD
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(100 + i));
    bus.in_valid = 1'b0;
    check("t6_hold_valid", 32'(bus.out_valid), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t6_clr_hold_valid", 32'(bus.out_valid), 32'd0);
    check("t6_clr_hold_ready", 32'(bus.in_ready), 32'd1);
    check("t6_clr_hold_max", 32'(bus.out_max), 32'd0);
    bus.out_ready = 1'b1;

    // clr with simultaneous accept: sample dropped
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_clr_acc_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      send(8'd2);
      if (i == 6) check("t6_no_early_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    check("t6_out_valid", 32'(bus.out_valid), 32'd1);
    check("t6_out_max", 32'(bus.out_max), 32'd2);
    chk_idx("t6_out_idx", 0);
    tick();
    check("t6_final_valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
